// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the bin2bcd double-dabble converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bin2bcd_if.sv
// Start/done request bus between a value producer and the bin2bcd converter.
interface bin2bcd_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, blank);
  modport slave  (input start, bin, output busy, done, bcd, blank);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  assign q = (d >= ADJ_THRESHOLD) ? d + ADJ_ADD : d;
endmodule

// File: rtl/bin2bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock; result is bin mod 10^DIGITS.
// Optional leading-zero mask built only when BIN2BCD_BLANK_EN is defined.
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic     clk,
  input  logic     reset,
  bin2bcd_if.slave io
);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   bin_shift;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_next;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(work[DIGIT_W*i +: DIGIT_W]),
      .q(work_adj[DIGIT_W*i +: DIGIT_W])
    );
  end

  // The bit leaving the top digit is dropped, which yields the mod 10^DIGITS result.
  assign work_next = {work_adj[BCD_W-2:0], bin_shift[WIDTH-1]};
  assign last      = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_shift <= '0;
      work      <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
    end else if (state == SHIFT) begin
      work      <= work_next;
      bin_shift <= bin_shift << 1;
      cnt       <= cnt + CNT_W'(1);
      if (last) begin
        bcd_q <= work_next;
        state <= DONE;
      end
    end else if (io.start) begin
      bin_shift <= io.bin;
      work      <= '0;
      cnt       <= '0;
      state     <= SHIFT;
    end else begin
      state <= IDLE;
    end
  end

  assign io.busy = (state == SHIFT);
  assign io.done = (state == DONE);
  assign io.bcd  = bcd_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic [DIGITS-1:0] blank_q;
  logic              zero_above;

  // Digit 0 is never blanked so that a zero value still shows one digit.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (work_next[DIGIT_W*i +: DIGIT_W] == '0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= '0;
    end else if (state == SHIFT && last) begin
      blank_q <= blank_next;
    end
  end

  assign io.blank = blank_q;
`else
  assign io.blank = '0;
`endif

endmodule
